fault_fsm: RTL and testbench
============================

Name: fault_fsm

Overview:
- Power-stage fault supervisor with four monitor flags: over-voltage, under-voltage, over-temperature and under-current.
- Each flag is individually masked and debounced. Faults escalate through NORMAL → WARNING → FAULT → SHUTDOWN the longer the condition persists.
- Sits between the analog comparator flag synchronizers and the gate-drive enable/host status logic.

Parameters:
- DEBOUNCE, 4, consecutive cycles a raw unmasked flag must be high before it counts as valid.
- WARN_TO_FAULT, 12, cycles a valid fault must persist in WARNING before moving to FAULT.
- FAULT_TO_SHUTDOWN, 16, cycles a valid fault must persist in FAULT before moving to SHUTDOWN.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ov, uv, ot, uc  in  1 each  raw fault flags, already synchronized, active-high.
- mask_ov, mask_uv, mask_ot, mask_uc  in  1 each  1 = ignore the corresponding flag.
- clear_warning  in  1  level; acknowledges and clears WARNING or FAULT once no fault is valid.
- state  out  2  0=NORMAL, 1=WARNING, 2=FAULT, 3=SHUTDOWN.
- warn  out  1  high exactly when state==WARNING.
- fault  out  1  high exactly when state==FAULT.
- shutdown  out  1  high exactly when state==SHUTDOWN.
- active_fault_id  out  3  0=none, 1=OV, 2=UV, 3=OT, 4=UC.

Behaviour:
- Reset values: state=NORMAL, warn=fault=shutdown=0, active_fault_id=0. All debounce and persistence counters are 0.
- Debounce, per flag x:
  - The counter increments, saturating at DEBOUNCE, while (x & ~mask_x).
  - It clears to 0 in any cycle where x=0 or mask_x=1.
  - valid_x=1 when the counter equals DEBOUNCE.
  - any_valid = OR of all valid_x.
- Masking a flag mid-event drops its valid_x on the next edge.
- Priority when several flags are valid: OV > UV > OT > UC. cur_id is the id of the highest-priority valid flag.
- Persistence counter:
  - Counts cycles with any_valid=1 while in WARNING or FAULT.
  - Clears on any state change, or when any_valid=0.
- NORMAL:
  - any_valid → WARNING on the next edge; active_fault_id is loaded with cur_id.
- WARNING:
  - While any_valid, active_fault_id tracks cur_id.
  - Persistence counter reaches WARN_TO_FAULT → FAULT.
  - any_valid=0 and clear_warning=1 → NORMAL, and active_fault_id becomes 0.
  - any_valid=0 with no clear → stay in WARNING (sticky).
- FAULT:
  - active_fault_id is frozen.
  - Persistence counter reaches FAULT_TO_SHUTDOWN → SHUTDOWN.
  - any_valid=0 and clear_warning=1 → NORMAL, and active_fault_id becomes 0.
  - Otherwise stay in FAULT.
- SHUTDOWN:
  - Terminal state. Only rst leaves it.
  - active_fault_id stays frozen.
  - Inputs, masks and clear_warning are ignored.
- clear_warning has no effect while any_valid=1, in NORMAL, or in SHUTDOWN.
- Outputs are registered decodes of the state register; there is no combinational path from the inputs.
- Latency: a flag first high at edge k yields valid at edge k+DEBOUNCE-1 and WARNING at edge k+DEBOUNCE. FAULT follows WARN_TO_FAULT edges later; SHUTDOWN follows FAULT_TO_SHUTDOWN edges after that.
- A flag dropping even one cycle during debounce restarts its count.
- rst asserted in any state returns everything to reset values on the next edge.

Test Plan:
- 1-cycle uc pulse after reset → state stays 0, all outputs 0, active_fault_id=0.
- ov held 20 cycles → warn=1 with id=1 about 4 cycles in, then fault=1, state=2 about 12 cycles later. Drop ov and hold 2 cycles of clear_warning → state=0, id=0.
- uc held 40 cycles → WARNING (id=4), then FAULT, then shutdown=1, state=3. Dropping uc and pulsing clear_warning leaves state=3; only rst restores 0.
- mask_uc=1 with uc held 20 cycles → state stays 0. Unmasking mid-hold restarts the debounce, giving WARNING DEBOUNCE+1 edges later.
- ov and uc asserted together → id=1. Drop ov while still in WARNING → id=4.
- In WARNING, clear_warning while a flag is still valid → no change. Flag gone without clear → state stays 1.

Source files
------------

// File: rtl/fault_fsm.sv
// Power-stage fault supervisor: per-flag mask and debounce, then NORMAL -> WARNING -> FAULT -> SHUTDOWN
// escalation driven by how long any debounced fault persists.
module fault_fsm #(
  parameter int unsigned DEBOUNCE          = 4,
  parameter int unsigned WARN_TO_FAULT     = 12,
  parameter int unsigned FAULT_TO_SHUTDOWN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ov,
  input  logic       uv,
  input  logic       ot,
  input  logic       uc,
  input  logic       mask_ov,
  input  logic       mask_uv,
  input  logic       mask_ot,
  input  logic       mask_uc,
  input  logic       clear_warning,
  output logic [1:0] state,
  output logic       warn,
  output logic       fault,
  output logic       shutdown,
  output logic [2:0] active_fault_id
);

  localparam int unsigned DW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned PMAX   = (WARN_TO_FAULT > FAULT_TO_SHUTDOWN) ? WARN_TO_FAULT : FAULT_TO_SHUTDOWN;
  localparam int unsigned PW     = $clog2(PMAX + 1);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_FAULT    = 2'd2,
    ST_SHUTDOWN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pers_q, pers_d, pers_inc;
  logic [2:0]      id_q, id_d;
  logic            warn_q, warn_d, fault_q, fault_d, shut_q, shut_d;
  logic [DW-1:0]   deb_q [4];
  logic [DW-1:0]   deb_d [4];
  logic [3:0]      raw, msk, valid;
  logic            any_valid;
  logic [2:0]      cur_id;

  assign raw = {uc, ot, uv, ov};
  assign msk = {mask_uc, mask_ot, mask_uv, mask_ov};

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      deb_d[i] = '0;
      if (raw[i] && !msk[i]) begin
        deb_d[i] = (deb_q[i] == DW'(DEBOUNCE)) ? deb_q[i] : deb_q[i] + 1'b1;
      end
      valid[i] = (deb_q[i] == DW'(DEBOUNCE));
    end
  end

  assign any_valid = |valid;

  always_comb begin
    if (valid[0])      cur_id = 3'd1;
    else if (valid[1]) cur_id = 3'd2;
    else if (valid[2]) cur_id = 3'd3;
    else if (valid[3]) cur_id = 3'd4;
    else               cur_id = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      pers_q  <= '0;
      id_q    <= '0;
      warn_q  <= 1'b0;
      fault_q <= 1'b0;
      shut_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) deb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pers_q  <= pers_d;
      id_q    <= id_d;
      warn_q  <= warn_d;
      fault_q <= fault_d;
      shut_q  <= shut_d;
      for (int unsigned i = 0; i < 4; i++) deb_q[i] <= deb_d[i];
    end
  end

  // pers_inc is the count including this cycle; the threshold is hit on the edge it reaches the limit.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pers_inc = pers_q + 1'b1;
    case (state_q)
      ST_NORMAL: begin
        if (any_valid) begin
          state_d = ST_WARNING;
          id_d    = cur_id;
        end
      end
      ST_WARNING: begin
        if (any_valid) begin
          id_d = cur_id;
          if (pers_inc == PW'(WARN_TO_FAULT)) state_d = ST_FAULT;
        end else if (clear_warning) begin
          state_d = ST_NORMAL;
          id_d    = '0;
        end
      end
      ST_FAULT: begin
        if (any_valid) begin
          if (pers_inc == PW'(FAULT_TO_SHUTDOWN)) state_d = ST_SHUTDOWN;
        end else if (clear_warning) begin
          state_d = ST_NORMAL;
          id_d    = '0;
        end
      end
      default: ;
    endcase
    pers_d = '0;
    if (state_d == state_q && any_valid && (state_q == ST_WARNING || state_q == ST_FAULT)) begin
      pers_d = pers_inc;
    end
  end

  always_comb begin
    warn_d  = (state_d == ST_WARNING);
    fault_d = (state_d == ST_FAULT);
    shut_d  = (state_d == ST_SHUTDOWN);
  end

  assign state           = state_q;
  assign warn            = warn_q;
  assign fault           = fault_q;
  assign shutdown        = shut_q;
  assign active_fault_id = id_q;

endmodule

// File: tb/tb_fault_fsm.sv
// Self-checking bench for fault_fsm: directed scenarios plus randomized traffic against a cycle model.
module tb_fault_fsm;

  localparam int DEB = 4;
  localparam int W2F = 12;
  localparam int F2S = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ov, uv, ot, uc;
  logic       mask_ov, mask_uv, mask_ot, mask_uc;
  logic       clear_warning;
  logic [1:0] state;
  logic       warn, fault, shutdown;
  logic [2:0] active_fault_id;

  int tests = 0;
  int fails = 0;

  // reference model: consecutive-high run lengths, state number, dwell with a valid fault, fault id
  int m_run [4];
  int m_st;
  int m_dwell;
  int m_id;

  fault_fsm #(
    .DEBOUNCE(DEB),
    .WARN_TO_FAULT(W2F),
    .FAULT_TO_SHUTDOWN(F2S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ov(ov),
    .uv(uv),
    .ot(ot),
    .uc(uc),
    .mask_ov(mask_ov),
    .mask_uv(mask_uv),
    .mask_ot(mask_ot),
    .mask_uc(mask_uc),
    .clear_warning(clear_warning),
    .state(state),
    .warn(warn),
    .fault(fault),
    .shutdown(shutdown),
    .active_fault_id(active_fault_id)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int flag [4];
    int mk [4];
    int any;
    int cur;
    int nst;
    int nid;
    flag[0] = ov; flag[1] = uv; flag[2] = ot; flag[3] = uc;
    mk[0] = mask_ov; mk[1] = mask_uv; mk[2] = mask_ot; mk[3] = mask_uc;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_st = 0; m_dwell = 0; m_id = 0;
    end else begin
      any = 0; cur = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_run[i] >= DEB) begin
          any = 1;
          if (cur == 0) cur = i + 1;
        end
      end
      nst = m_st; nid = m_id;
      if (m_st == 0) begin
        if (any != 0) begin nst = 1; nid = cur; end
      end else if (m_st == 1) begin
        if (any != 0) begin
          nid = cur;
          if (m_dwell + 1 == W2F) nst = 2;
        end else if (clear_warning) begin nst = 0; nid = 0; end
      end else if (m_st == 2) begin
        if (any != 0) begin
          if (m_dwell + 1 == F2S) nst = 3;
        end else if (clear_warning) begin nst = 0; nid = 0; end
      end
      if (nst == m_st && any != 0 && (m_st == 1 || m_st == 2)) m_dwell = m_dwell + 1;
      else m_dwell = 0;
      for (int i = 0; i < 4; i++) begin
        if (flag[i] != 0 && mk[i] == 0) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
        else m_run[i] = 0;
      end
      m_st = nst; m_id = nid;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    {ov, uv, ot, uc} = '0;
    {mask_ov, mask_uv, mask_ot, mask_uc} = '0;
    clear_warning = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if ({state, warn, fault, shutdown, active_fault_id} !== 8'h00) begin
      fails++;
      $display("FAIL reset: outputs=%h expected 00", {state, warn, fault, shutdown, active_fault_id});
    end
  endtask

  task automatic test_uc_pulse();
    uc = 1'b1;
    step();
    uc = 1'b0;
    repeat (8) step();
    tests++;
    if ({state, warn, fault, shutdown, active_fault_id} !== 8'h00) begin
      fails++;
      $display("FAIL uc_pulse: outputs=%h expected 00", {state, warn, fault, shutdown, active_fault_id});
    end
  endtask

  task automatic test_ov_warn_fault();
    ov = 1'b1;
    repeat (DEB) step();
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL ov_pre_warn: state=%0d expected 0", state); end
    step();
    tests++;
    if (state !== 2'd1 || warn !== 1'b1 || active_fault_id !== 3'd1) begin
      fails++;
      $display("FAIL ov_warn: state=%0d warn=%b id=%0d expected 1 1 1", state, warn, active_fault_id);
    end
    repeat (W2F - 1) step();
    tests++;
    if (state !== 2'd1) begin fails++; $display("FAIL ov_pre_fault: state=%0d expected 1", state); end
    step();
    tests++;
    if (state !== 2'd2 || fault !== 1'b1 || warn !== 1'b0 || active_fault_id !== 3'd1) begin
      fails++;
      $display("FAIL ov_fault: state=%0d fault=%b warn=%b id=%0d expected 2 1 0 1", state, fault, warn, active_fault_id);
    end
    repeat (3) step();
    ov = 1'b0;
    clear_warning = 1'b1;
    step();
    step();
    clear_warning = 1'b0;
    tests++;
    if (state !== 2'd0 || fault !== 1'b0 || active_fault_id !== 3'd0) begin
      fails++;
      $display("FAIL ov_clear: state=%0d fault=%b id=%0d expected 0 0 0", state, fault, active_fault_id);
    end
  endtask

  task automatic test_uc_shutdown();
    uc = 1'b1;
    repeat (DEB + 1) step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL uc_warn: state=%0d id=%0d expected 1 4", state, active_fault_id);
    end
    repeat (W2F) step();
    tests++;
    if (state !== 2'd2 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL uc_fault: state=%0d id=%0d expected 2 4", state, active_fault_id);
    end
    repeat (F2S - 1) step();
    tests++;
    if (state !== 2'd2) begin fails++; $display("FAIL uc_pre_shutdown: state=%0d expected 2", state); end
    step();
    tests++;
    if (state !== 2'd3 || shutdown !== 1'b1 || fault !== 1'b0 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL uc_shutdown: state=%0d shutdown=%b fault=%b id=%0d expected 3 1 0 4", state, shutdown, fault, active_fault_id);
    end
    repeat (7) step();
    uc = 1'b0;
    step();
    clear_warning = 1'b1;
    step();
    clear_warning = 1'b0;
    step();
    tests++;
    if (state !== 2'd3 || shutdown !== 1'b1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL shutdown_sticky: state=%0d shutdown=%b id=%0d expected 3 1 4", state, shutdown, active_fault_id);
    end
    do_reset();
    tests++;
    if ({state, warn, fault, shutdown, active_fault_id} !== 8'h00) begin
      fails++;
      $display("FAIL shutdown_rst: outputs=%h expected 00", {state, warn, fault, shutdown, active_fault_id});
    end
  endtask

  task automatic test_mask();
    mask_uc = 1'b1;
    uc = 1'b1;
    repeat (20) step();
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL mask_hold: state=%0d expected 0", state); end
    mask_uc = 1'b0;
    repeat (DEB) step();
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL unmask_pre: state=%0d expected 0", state); end
    step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL unmask_warn: state=%0d id=%0d expected 1 4", state, active_fault_id);
    end
    uc = 1'b0;
    do_reset();
  endtask

  task automatic test_glitch();
    ov = 1'b1;
    repeat (DEB - 1) step();
    ov = 1'b0;
    step();
    ov = 1'b1;
    repeat (DEB) step();
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL glitch_restart: state=%0d expected 0", state); end
    step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd1) begin
      fails++;
      $display("FAIL glitch_warn: state=%0d id=%0d expected 1 1", state, active_fault_id);
    end
    ov = 1'b0;
    do_reset();
  endtask

  task automatic test_priority();
    ov = 1'b1;
    uc = 1'b1;
    repeat (DEB + 1) step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd1) begin
      fails++;
      $display("FAIL prio_both: state=%0d id=%0d expected 1 1", state, active_fault_id);
    end
    ov = 1'b0;
    step();
    tests++;
    if (active_fault_id !== 3'd1) begin fails++; $display("FAIL prio_drop_lag: id=%0d expected 1", active_fault_id); end
    step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL prio_track: state=%0d id=%0d expected 1 4", state, active_fault_id);
    end
  endtask

  task automatic test_clear_while_valid();
    clear_warning = 1'b1;
    repeat (2) step();
    tests++;
    if (state !== 2'd1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL clear_valid: state=%0d id=%0d expected 1 4", state, active_fault_id);
    end
    clear_warning = 1'b0;
    uc = 1'b0;
    repeat (3) step();
    tests++;
    if (state !== 2'd1 || warn !== 1'b1 || active_fault_id !== 3'd4) begin
      fails++;
      $display("FAIL warn_sticky: state=%0d warn=%b id=%0d expected 1 1 4", state, warn, active_fault_id);
    end
    clear_warning = 1'b1;
    step();
    clear_warning = 1'b0;
    tests++;
    if (state !== 2'd0 || warn !== 1'b0 || active_fault_id !== 3'd0) begin
      fails++;
      $display("FAIL warn_clear: state=%0d warn=%b id=%0d expected 0 0 0", state, warn, active_fault_id);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) ov = ~ov;
      if ($urandom_range(0, 13) == 0) uv = ~uv;
      if ($urandom_range(0, 15) == 0) ot = ~ot;
      if ($urandom_range(0, 9) == 0)  uc = ~uc;
      if ($urandom_range(0, 63) == 0) mask_ov = ~mask_ov;
      if ($urandom_range(0, 63) == 0) mask_uv = ~mask_uv;
      if ($urandom_range(0, 63) == 0) mask_ot = ~mask_ot;
      if ($urandom_range(0, 63) == 0) mask_uc = ~mask_uc;
      clear_warning = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 249) == 0);
      step();
      exp = {m_st[1:0], m_st == 1, m_st == 2, m_st == 3, m_id[2:0]};
      tests++;
      if ({state, warn, fault, shutdown, active_fault_id} !== exp) begin
        fails++;
        $display("FAIL random cycle %0d: state/warn/fault/shut/id=%h expected %h", c,
                 {state, warn, fault, shutdown, active_fault_id}, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_st = 0; m_dwell = 0; m_id = 0;
    idle_inputs();
    test_reset();
    test_uc_pulse();
    test_ov_warn_fault();
    test_uc_shutdown();
    test_mask();
    test_glitch();
    test_priority();
    test_clear_while_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
